// File: rtl/max_idx_seq.sv
// max_idx_seq: sequential arg-max over N candidates using NCMP shared comparators.
// Returns the lowest index holding the largest value; optional max_val output.
//
// Ports:
//   clk      rising-edge clock
//   reset_n  asynchronous active-low reset
//   inputs   N candidate numbers, WIDTH bits each, sampled when start is accepted
//   start    request, accepted only while busy is low
//   busy     high from the acceptance edge until the done edge
//   done     one-cycle pulse, idx (and max_val) valid from this cycle on
//   idx      index of the maximum, held until the next done
//   max_val  maximum value (only when MAX_IDX_SEQ_VALUE_EN is defined)
//
// Build option: define MAX_IDX_SEQ_VALUE_EN to add the registered max_val port.

module max_idx_seq #(
    parameter int WIDTH  = 8,
    parameter int N      = 10,
    parameter int NCMP   = 3,
    parameter bit SIGNED = 1'b1,
    localparam int IDX_W = $clog2(N)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] inputs [N],
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic [IDX_W-1:0] idx
`ifdef MAX_IDX_SEQ_VALUE_EN
    ,
    output logic [WIDTH-1:0] max_val
`endif
);

    // Comparators beyond N/2 could never receive a pair, so they are not built.
    localparam int HALF  = N / 2;
    localparam int NC    = (NCMP < HALF) ? NCMP : HALF;
    localparam int CNT_W = $clog2(N + 1);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t state;

    // Working arrays: candidate values and their original indices.
    logic [WIDTH-1:0] w_n [N];
    logic [IDX_W-1:0] w_d [N];
    logic [CNT_W-1:0] n;

    logic [WIDTH-1:0] nx_n [N];
    logic [IDX_W-1:0] nx_d [N];
    logic [CNT_W-1:0] n_nx;
    logic [CNT_W-1:0] half_n;
    logic [CNT_W-1:0] p;

    logic [WIDTH-1:0] win_n [NC];
    logic [IDX_W-1:0] win_d [NC];

    logic accept;

    assign accept = (state == IDLE) && start;

    // Pair comparators: b replaces a only when strictly greater, so ties keep
    // the earlier entry and the lowest original index survives.
    for (genvar k = 0; k < NC; k++) begin : g_cmp
        logic b_gt;
        if (SIGNED) begin : g_s
            assign b_gt = $signed(w_n[2*k+1]) > $signed(w_n[2*k]);
        end else begin : g_u
            assign b_gt = w_n[2*k+1] > w_n[2*k];
        end
        assign win_n[k] = b_gt ? w_n[2*k+1] : w_n[2*k];
        assign win_d[k] = b_gt ? w_d[2*k+1] : w_d[2*k];
    end

    // Pairs used this round: min(NC, n/2).
    always_comb begin
        half_n = n >> 1;
        p      = (half_n < CNT_W'(NC)) ? half_n : CNT_W'(NC);
        n_nx   = n - p;
    end

    // Next working arrays: winners fill [0..p-1]; the unpaired tail
    // [2p..n-1] slides down to [p..n-p-1], keeping its order.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            nx_n[i] = w_n[i];
            nx_d[i] = w_d[i];
            if (i >= int'(p) && (i + int'(p)) < int'(n)) begin
                nx_n[i] = w_n[IDX_W'(i) + IDX_W'(p)];
                nx_d[i] = w_d[IDX_W'(i) + IDX_W'(p)];
            end
        end
        for (int k = 0; k < NC; k++) begin
            if (CNT_W'(k) < p) begin
                nx_n[k] = win_n[k];
                nx_d[k] = win_d[k];
            end
        end
    end

    // Datapath storage is not reset; its contents only matter once loaded.
    always_ff @(posedge clk) begin
        if (accept) begin
            for (int i = 0; i < N; i++) begin
                w_n[i] <= inputs[i];
                w_d[i] <= IDX_W'(i);
            end
            n <= CNT_W'(N);
        end else if (state == RUN) begin
            for (int i = 0; i < N; i++) begin
                w_n[i] <= nx_n[i];
                w_d[i] <= nx_d[i];
            end
            n <= n_nx;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            idx     <= '0;
`ifdef MAX_IDX_SEQ_VALUE_EN
            max_val <= '0;
`endif
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (n_nx == CNT_W'(1)) begin
                        idx     <= nx_d[0];
`ifdef MAX_IDX_SEQ_VALUE_EN
                        max_val <= nx_n[0];
`endif
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_max_idx_seq.sv
// tb_max_idx_seq: directed and randomized checks of max_idx_seq against a
// lowest-index arg-max model and the round-count formula.

module tb_max_idx_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic       reset_n;
    logic [7:0] in_a [10];
    logic       start_a;
    logic       busy_a, done_a, busy_u, done_u;
    logic [3:0] idx_a, idx_u;
`ifdef MAX_IDX_SEQ_VALUE_EN
    logic [7:0] mv_a, mv_u;
`endif

    int checks = 0;
    int failures = 0;

    max_idx_seq #(.WIDTH(8), .N(10), .NCMP(3), .SIGNED(1'b1)) dut_a (
        .clk(clk), .reset_n(reset_n), .inputs(in_a), .start(start_a),
        .busy(busy_a), .done(done_a), .idx(idx_a)
`ifdef MAX_IDX_SEQ_VALUE_EN
        , .max_val(mv_a)
`endif
    );

    max_idx_seq #(.WIDTH(8), .N(10), .NCMP(3), .SIGNED(1'b0)) dut_u (
        .clk(clk), .reset_n(reset_n), .inputs(in_a), .start(start_a),
        .busy(busy_u), .done(done_u), .idx(idx_u)
`ifdef MAX_IDX_SEQ_VALUE_EN
        , .max_val(mv_u)
`endif
    );

    // Sweep instances: N in {2,5,17} x NCMP in {1,2,4}, all signed.
    logic [7:0] pool [17];
    logic       start_s;
    int sw_dcyc [9];
    int sw_idx  [9];
    int sw_dcnt [9];
    int sw_bcnt [9];

    for (genvar gi = 0; gi < 3; gi++) begin : g_n
        for (genvar gj = 0; gj < 3; gj++) begin : g_c
            localparam int SN = (gi == 0) ? 2 : ((gi == 1) ? 5 : 17);
            localparam int SC = (gj == 0) ? 1 : ((gj == 1) ? 2 : 4);
            logic [7:0] vin [SN];
            logic sbusy, sdone;
            logic [$clog2(SN)-1:0] sidx;
`ifdef MAX_IDX_SEQ_VALUE_EN
            logic [7:0] smv;
`endif
            int dcyc = 0;
            int gidx = 0;
            int dcnt = 0;
            int bcnt = 0;
            for (genvar k = 0; k < SN; k++) begin : g_in
                assign vin[k] = pool[k];
            end
            max_idx_seq #(.WIDTH(8), .N(SN), .NCMP(SC), .SIGNED(1'b1)) dut (
                .clk(clk), .reset_n(reset_n), .inputs(vin), .start(start_s),
                .busy(sbusy), .done(sdone), .idx(sidx)
`ifdef MAX_IDX_SEQ_VALUE_EN
                , .max_val(smv)
`endif
            );
            always @(negedge clk) begin
                if (sdone === 1'b1) begin
                    dcyc = cyc;
                    gidx = int'(sidx);
                    dcnt = dcnt + 1;
                end
                if (sbusy === 1'b1) bcnt = bcnt + 1;
            end
            assign sw_dcyc[gi*3+gj] = dcyc;
            assign sw_idx[gi*3+gj]  = gidx;
            assign sw_dcnt[gi*3+gj] = dcnt;
            assign sw_bcnt[gi*3+gj] = bcnt;
        end
    end

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Reference: rounds from n <- n - min(c, n/2) until n == 1.
    function automatic int rounds(input int n, input int c);
        int r = 0;
        int m = n;
        while (m > 1) begin
            m = m - ((c < m / 2) ? c : m / 2);
            r++;
        end
        return r;
    endfunction

    // Reference: first index of the signed maximum of pool[0..n-1].
    function automatic int argmax(input int n);
        int b = 0;
        for (int k = 1; k < n; k++)
            if ($signed(pool[k]) > $signed(pool[b])) b = k;
        return b;
    endfunction

    task automatic go_a(input string tag, input int lat, input int ix, input int val);
        int c;
        int bc;
        @(negedge clk);
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        c = 0;
        bc = 0;
        while (done_a !== 1'b1 && c < 60) begin
            bc += int'(busy_a);
            @(negedge clk);
            c++;
        end
        chk({tag, "_lat"}, c, lat);
        chk({tag, "_idx"}, int'(idx_a), ix);
        chk({tag, "_busycyc"}, bc, lat);
        chk({tag, "_busy_at_done"}, int'(busy_a), 0);
`ifdef MAX_IDX_SEQ_VALUE_EN
        chk({tag, "_val"}, int'(mv_a), val & 255);
`endif
        @(negedge clk);
        chk({tag, "_done_pulse"}, int'(done_a), 0);
    endtask

    initial begin
        int c;
        int dn;
        reset_n = 1'b0;
        start_a = 1'b0;
        start_s = 1'b0;
        for (int i = 0; i < 10; i++) in_a[i] = 8'h00;
        for (int i = 0; i < 17; i++) pool[i] = 8'h00;
        repeat (2) @(negedge clk);
        chk("rst_busy", int'(busy_a), 0);
        chk("rst_done", int'(done_a), 0);
        chk("rst_idx", int'(idx_a), 0);
`ifdef MAX_IDX_SEQ_VALUE_EN
        chk("rst_val", int'(mv_a), 0);
`endif
        reset_n = 1'b1;

        in_a = '{8'hFB, 8'd3, 8'd7, 8'h80, 8'd7, 8'd2, 8'd0, 8'd127, 8'd1, 8'hFF};
        go_a("basic", 4, 7, 127);

        for (int i = 0; i < 10; i++) in_a[i] = 8'h00;
        go_a("tie0", 4, 0, 0);

        in_a = '{8'd1, 8'd0, 8'd7, 8'hFD, 8'd7, 8'd5, 8'd6, 8'hFF, 8'd2, 8'd0};
        go_a("tie7", 4, 2, 7);

        // Abort during round 2: everything drops asynchronously, no done later.
        in_a = '{8'hFB, 8'd3, 8'd7, 8'h80, 8'd7, 8'd2, 8'd0, 8'd127, 8'd1, 8'hFF};
        @(negedge clk);
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        chk("abort_busy", int'(busy_a), 0);
        chk("abort_done", int'(done_a), 0);
        chk("abort_idx", int'(idx_a), 0);
        @(negedge clk);
        reset_n = 1'b1;
        dn = 0;
        repeat (8) begin
            @(negedge clk);
            dn += int'(done_a);
        end
        chk("abort_no_done", dn, 0);
        chk("abort_idx_hold", int'(idx_a), 0);

        for (int i = 0; i < 10; i++) in_a[i] = 8'h7F;
        in_a[3] = 8'h80;
        go_a("signed", 4, 0, 127);
        chk("unsigned_idx", int'(idx_u), 3);
        chk("unsigned_busy", int'(busy_u), 0);
`ifdef MAX_IDX_SEQ_VALUE_EN
        chk("unsigned_val", int'(mv_u), 128);
`endif

        // Handshake: start held through busy and done, inputs changed mid-run.
        for (int i = 0; i < 10; i++) in_a[i] = 8'hFF;
        in_a[9] = 8'd100;
        @(negedge clk);
        start_a = 1'b1;
        @(negedge clk);
        chk("hs_busy", int'(busy_a), 1);
        in_a[0] = 8'd127;
        c = 0;
        while (done_a !== 1'b1 && c < 60) begin
            @(negedge clk);
            c++;
        end
        chk("hs1_lat", c, 4);
        chk("hs1_idx", int'(idx_a), 9);
`ifdef MAX_IDX_SEQ_VALUE_EN
        chk("hs1_val", int'(mv_a), 100);
`endif
        @(negedge clk);
        start_a = 1'b0;
        chk("hs2_busy", int'(busy_a), 1);
        chk("hs2_done_low", int'(done_a), 0);
        c = 0;
        while (done_a !== 1'b1 && c < 60) begin
            @(negedge clk);
            c++;
        end
        chk("hs2_lat", c, 4);
        chk("hs2_idx", int'(idx_a), 0);
`ifdef MAX_IDX_SEQ_VALUE_EN
        chk("hs2_val", int'(mv_a), 127);
`endif
        @(negedge clk);

        // Randomized sweep over all nine configurations at once.
        for (int it = 0; it < 6; it++) begin
            int bc_before [9];
            int dc_before [9];
            int t_acc;
            for (int k = 0; k < 17; k++)
                pool[k] = (it % 2 == 0) ? 8'($urandom) : 8'($urandom_range(0, 3));
            for (int g = 0; g < 9; g++) begin
                bc_before[g] = sw_bcnt[g];
                dc_before[g] = sw_dcnt[g];
            end
            @(negedge clk);
            start_s = 1'b1;
            t_acc = cyc + 1;
            @(negedge clk);
            start_s = 1'b0;
            repeat (20) @(negedge clk);
            for (int g = 0; g < 9; g++) begin
                int sn;
                int sc;
                int r;
                sn = (g / 3 == 0) ? 2 : ((g / 3 == 1) ? 5 : 17);
                sc = (g % 3 == 0) ? 1 : ((g % 3 == 1) ? 2 : 4);
                r = rounds(sn, sc);
                chk($sformatf("sw%0d_n%0d_c%0d_dones", it, sn, sc), sw_dcnt[g] - dc_before[g], 1);
                chk($sformatf("sw%0d_n%0d_c%0d_lat", it, sn, sc), sw_dcyc[g] - t_acc, r);
                chk($sformatf("sw%0d_n%0d_c%0d_busy", it, sn, sc), sw_bcnt[g] - bc_before[g], r);
                chk($sformatf("sw%0d_n%0d_c%0d_idx", it, sn, sc), sw_idx[g], argmax(sn));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
